// File: rtl/uart_rx_os16_pkg.sv
// Shared state encoding and helpers for the 16x-oversampled UART receiver.
package uart_rx_os16_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rxState_e;

    localparam int OS_CNT_W = 4;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic int calcDiv(input int clkFreq, input int bps, input int osr);
        return clkFreq / (bps * osr);
    endfunction

endpackage

// File: rtl/uart_rx_os16_baud_tick.sv
// Oversample tick generator: divides sys_clk by DIV, restartable by a synchronous clear.
module uart_baud_tick
    import uart_rx_os16_pkg::*;
#(
    parameter int DIV = 325
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clear_i,
    output logic os_tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign os_tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 8-bit UART receiver: 16x oversampling, 3-sample majority vote, glitch rejection,
// optional parity, and frame/parity error pulses.
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OSR        = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       par_err
);

    localparam int DIV = calcDiv(CLK_FREQ, UART_BPS, OSR);
    localparam logic [OS_CNT_W-1:0] LAST_OS = OS_CNT_W'(OSR - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    logic rxMeta_q, rxSync_q, rxPrev_q;
    logic [1:0] settle_q;
    logic armed_q;
    logic fallEdge, osTick, decide, bitEnd, maj;

    rxState_e state_q, state_d;
    logic [OS_CNT_W-1:0] osCnt_q, osCnt_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] shift_q, shift_d;
    logic parMis_q, parMis_d;
    logic [7:0] poData_q, poData_d;
    logic poFlag_q, poFlag_d;
    logic frameErr_q, frameErr_d;
    logic parErr_q, parErr_d;

    // Edges are only trusted once the synchroniser has flushed its reset value and the
    // line has been seen high, so a line still low after reset cannot fake a start bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
            settle_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
            settle_q <= {settle_q[0], 1'b1};
            armed_q  <= armed_q | (settle_q[1] & rxSync_q);
        end
    end

    assign fallEdge = armed_q & rxPrev_q & ~rxSync_q;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .clear_i  (state_q == IDLE),
        .os_tick_o(osTick)
    );

    assign decide = osTick && (osCnt_q == 4'd9);
    assign bitEnd = osTick && (osCnt_q == LAST_OS);
    assign maj    = majority3(samp_q[0], samp_q[1], rxSync_q);

    always_comb begin
        state_d    = state_q;
        osCnt_d    = osCnt_q;
        bitCnt_d   = bitCnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        parMis_d   = parMis_q;
        poData_d   = poData_q;
        poFlag_d   = 1'b0;
        frameErr_d = 1'b0;
        parErr_d   = 1'b0;

        if (osTick) begin
            osCnt_d = (osCnt_q == LAST_OS) ? '0 : osCnt_q + 1'b1;
            if (osCnt_q == 4'd7) samp_d[0] = rxSync_q;
            if (osCnt_q == 4'd8) samp_d[1] = rxSync_q;
        end

        case (state_q)
            IDLE: begin
                osCnt_d  = '0;
                bitCnt_d = '0;
                if (fallEdge) begin
                    state_d  = START;
                    parMis_d = 1'b0;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                end else if (bitEnd) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) shift_d = {maj, shift_q[7:1]};
                if (bitEnd) begin
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == 3'd7) state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (decide) parMis_d = (maj != ((^shift_q) ^ PAR_ODD));
                if (bitEnd) state_d = STOP;
            end
            STOP: begin
                // Decide mid stop bit and leave early so back-to-back frames are caught.
                if (decide) begin
                    if (!maj) begin
                        frameErr_d = 1'b1;
                        state_d    = BREAK;
                    end else if (parMis_q) begin
                        parErr_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        poData_d = shift_q;
                        poFlag_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            BREAK: begin
                if (rxSync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            osCnt_q    <= '0;
            bitCnt_q   <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            parMis_q   <= 1'b0;
            poData_q   <= 8'h00;
            poFlag_q   <= 1'b0;
            frameErr_q <= 1'b0;
            parErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            osCnt_q    <= osCnt_d;
            bitCnt_q   <= bitCnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            parMis_q   <= parMis_d;
            poData_q   <= poData_d;
            poFlag_q   <= poFlag_d;
            frameErr_q <= frameErr_d;
            parErr_q   <= parErr_d;
        end
    end

    assign po_data   = poData_q;
    assign po_flag   = poFlag_q;
    assign frame_err = frameErr_q;
    assign par_err   = parErr_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: randomized frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_os16;

    localparam int      BPS      = 9600;
    localparam int      CLK_FREQ = 9600 * 16 * 4;
    localparam realtime BIT_NS   = 640.0;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic rxA = 1'b1;
    logic rxP = 1'b1;

    logic [7:0] poData, poDataP;
    logic poFlag, frameErr, parErr;
    logic poFlagP, frameErrP, parErrP;

    int assertCount = 0;
    int failCount = 0;

    logic [7:0] flagQ[$];
    logic [7:0] flagQP[$];
    int frameErrCnt = 0, parErrCnt = 0, frameErrCntP = 0, parErrCntP = 0;
    int ruleViol = 0, ruleViolP = 0;
    logic prevPulse = 1'b0, prevPulseP = 1'b0;
    logic [7:0] lastData = 8'h00, lastDataP = 8'h00;

    always #5 clk = ~clk;

    uart_rx_os16 #(
        .UART_BPS(BPS), .CLK_FREQ(CLK_FREQ), .OSR(16), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rstN), .rx(rxA),
        .po_data(poData), .po_flag(poFlag), .frame_err(frameErr), .par_err(parErr)
    );

    uart_rx_os16 #(
        .UART_BPS(BPS), .CLK_FREQ(CLK_FREQ), .OSR(16), .PARITY_EN(1), .PARITY_ODD(0)
    ) dutPar (
        .sys_clk(clk), .sys_rst_n(rstN), .rx(rxP),
        .po_data(poDataP), .po_flag(poFlagP), .frame_err(frameErrP), .par_err(parErrP)
    );

    // Record output events and flag any pulse-rule breach (overlap, repeats, silent data change).
    always @(negedge clk) begin
        if (poFlag) flagQ.push_back(poData);
        if (frameErr) frameErrCnt++;
        if (parErr) parErrCnt++;
        if ((int'(poFlag) + int'(frameErr) + int'(parErr)) > 1) ruleViol++;
        if (prevPulse && (poFlag || frameErr || parErr)) ruleViol++;
        if (rstN && !poFlag && poData !== lastData) ruleViol++;
        prevPulse = poFlag | frameErr | parErr;
        lastData = poData;
    end

    always @(negedge clk) begin
        if (poFlagP) flagQP.push_back(poDataP);
        if (frameErrP) frameErrCntP++;
        if (parErrP) parErrCntP++;
        if ((int'(poFlagP) + int'(frameErrP) + int'(parErrP)) > 1) ruleViolP++;
        if (prevPulseP && (poFlagP || frameErrP || parErrP)) ruleViolP++;
        if (rstN && !poFlagP && poDataP !== lastDataP) ruleViolP++;
        prevPulseP = poFlagP | frameErrP | parErrP;
        lastDataP = poDataP;
    end

    function automatic logic evenParityOk(input logic [7:0] d, input logic p);
        return (($countones(d) + int'(p)) % 2) == 0;
    endfunction

    task automatic driveLine(input bit target, input logic v);
        if (target) rxP = v;
        else rxA = v;
    endtask

    // A low stop bit leaves the line low; the caller decides when it returns high.
    task automatic sendFrame(input bit target, input logic [7:0] data, input bit withPar,
                             input logic parBit, input logic stopBit, input realtime bitNs,
                             input int idleBits);
        driveLine(target, 1'b0);
        #(bitNs);
        for (int i = 0; i < 8; i++) begin
            driveLine(target, data[i]);
            #(bitNs);
        end
        if (withPar) begin
            driveLine(target, parBit);
            #(bitNs);
        end
        driveLine(target, stopBit);
        #(bitNs);
        if (stopBit) begin
            driveLine(target, 1'b1);
            #(bitNs * idleBits);
        end
    endtask

    task automatic clearEvents();
        flagQ.delete();
        flagQP.delete();
        frameErrCnt = 0;
        parErrCnt = 0;
        frameErrCntP = 0;
        parErrCntP = 0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        #23;
        assertCount++;
        if (poData !== 8'h00) begin failCount++; $display("[TB] FAIL reset_po_data: got %h, expected 00", poData); end
        assertCount++;
        if (poFlag !== 1'b0) begin failCount++; $display("[TB] FAIL reset_po_flag: got %b, expected 0", poFlag); end
        assertCount++;
        if (frameErr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_frame_err: got %b, expected 0", frameErr); end
        assertCount++;
        if (parErr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_par_err: got %b, expected 0", parErr); end
        assertCount++;
        if (poDataP !== 8'h00) begin failCount++; $display("[TB] FAIL reset_po_data_par: got %h, expected 00", poDataP); end
        @(posedge clk);
        #2 rstN = 1'b1;
        #(BIT_NS);
        clearEvents();
    endtask

    task automatic test_basic();
        clearEvents();
        sendFrame(0, 8'h55, 0, 1'b0, 1'b1, BIT_NS, 2);
        assertCount++;
        if (flagQ.size() != 1) begin failCount++; $display("[TB] FAIL basic_flag_count: got %0d, expected 1", flagQ.size()); end
        else begin
            assertCount++;
            if (flagQ[0] !== 8'h55) begin failCount++; $display("[TB] FAIL basic_data: got %h, expected 55", flagQ[0]); end
        end
        assertCount++;
        if (frameErrCnt + parErrCnt != 0) begin failCount++; $display("[TB] FAIL basic_errors: got %0d, expected 0", frameErrCnt + parErrCnt); end
        assertCount++;
        if (poData !== 8'h55) begin failCount++; $display("[TB] FAIL basic_hold: got %h, expected 55", poData); end
    endtask

    task automatic test_back_to_back();
        clearEvents();
        sendFrame(0, 8'h00, 0, 1'b0, 1'b1, BIT_NS, 0);
        sendFrame(0, 8'hFF, 0, 1'b0, 1'b1, BIT_NS, 2);
        assertCount++;
        if (flagQ.size() != 2) begin failCount++; $display("[TB] FAIL b2b_flag_count: got %0d, expected 2", flagQ.size()); end
        else begin
            assertCount++;
            if (flagQ[0] !== 8'h00) begin failCount++; $display("[TB] FAIL b2b_first: got %h, expected 00", flagQ[0]); end
            assertCount++;
            if (flagQ[1] !== 8'hFF) begin failCount++; $display("[TB] FAIL b2b_second: got %h, expected ff", flagQ[1]); end
        end
    endtask

    task automatic test_glitch();
        clearEvents();
        rxA = 1'b0;
        #100;
        rxA = 1'b1;
        #(3 * BIT_NS);
        assertCount++;
        if (flagQ.size() != 0 || frameErrCnt != 0) begin
            failCount++;
            $display("[TB] FAIL glitch_reject: got flags=%0d frame_errs=%0d, expected 0/0", flagQ.size(), frameErrCnt);
        end
        sendFrame(0, 8'hA3, 0, 1'b0, 1'b1, BIT_NS, 2);
        assertCount++;
        if (flagQ.size() != 1) begin failCount++; $display("[TB] FAIL glitch_next_count: got %0d, expected 1", flagQ.size()); end
        else begin
            assertCount++;
            if (flagQ[0] !== 8'hA3) begin failCount++; $display("[TB] FAIL glitch_next_data: got %h, expected a3", flagQ[0]); end
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] held;
        held = 8'hA3;
        clearEvents();
        sendFrame(0, 8'h3C, 0, 1'b0, 1'b0, BIT_NS, 0);
        #(2 * BIT_NS);
        assertCount++;
        if (frameErrCnt != 1) begin failCount++; $display("[TB] FAIL ferr_count: got %0d, expected 1", frameErrCnt); end
        assertCount++;
        if (flagQ.size() != 0) begin failCount++; $display("[TB] FAIL ferr_no_flag: got %0d, expected 0", flagQ.size()); end
        assertCount++;
        if (poData !== held) begin failCount++; $display("[TB] FAIL ferr_data_held: got %h, expected %h", poData, held); end
        rxA = 1'b1;
        #(2 * BIT_NS);
        sendFrame(0, 8'h3C, 0, 1'b0, 1'b1, BIT_NS, 2);
        assertCount++;
        if (flagQ.size() != 1) begin failCount++; $display("[TB] FAIL ferr_recover_count: got %0d, expected 1", flagQ.size()); end
        else begin
            assertCount++;
            if (flagQ[0] !== 8'h3C) begin failCount++; $display("[TB] FAIL ferr_recover_data: got %h, expected 3c", flagQ[0]); end
        end
        assertCount++;
        if (frameErrCnt != 1) begin failCount++; $display("[TB] FAIL ferr_no_extra: got %0d, expected 1", frameErrCnt); end
    endtask

    task automatic test_parity();
        logic [7:0] expQ[$];
        logic [7:0] b;
        logic p;
        int expParErr;
        clearEvents();
        sendFrame(1, 8'h07, 1, 1'b0, 1'b1, BIT_NS, 2);
        assertCount++;
        if (parErrCntP != 1) begin failCount++; $display("[TB] FAIL par_bad_err: got %0d, expected 1", parErrCntP); end
        assertCount++;
        if (flagQP.size() != 0) begin failCount++; $display("[TB] FAIL par_bad_noflag: got %0d, expected 0", flagQP.size()); end
        assertCount++;
        if (poDataP !== 8'h00) begin failCount++; $display("[TB] FAIL par_bad_held: got %h, expected 00", poDataP); end
        clearEvents();
        sendFrame(1, 8'h07, 1, 1'b1, 1'b1, BIT_NS, 2);
        assertCount++;
        if (flagQP.size() != 1 || poDataP !== 8'h07) begin
            failCount++;
            $display("[TB] FAIL par_good: got flags=%0d data=%h, expected 1/07", flagQP.size(), poDataP);
        end
        clearEvents();
        expParErr = 0;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            sendFrame(1, b, 1, p, 1'b1, BIT_NS, int'($urandom_range(0, 2)));
            if (evenParityOk(b, p)) expQ.push_back(b);
            else expParErr++;
        end
        #(2 * BIT_NS);
        assertCount++;
        if (parErrCntP != expParErr) begin failCount++; $display("[TB] FAIL par_rand_errs: got %0d, expected %0d", parErrCntP, expParErr); end
        assertCount++;
        if (flagQP.size() != expQ.size()) begin failCount++; $display("[TB] FAIL par_rand_count: got %0d, expected %0d", flagQP.size(), expQ.size()); end
        else begin
            for (int i = 0; i < expQ.size(); i++) begin
                assertCount++;
                if (flagQP[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL par_rand_data[%0d]: got %h, expected %h", i, flagQP[i], expQ[i]); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        clearEvents();
        fork
            sendFrame(0, 8'h81, 0, 1'b0, 1'b1, BIT_NS, 2);
            begin
                #(4.5 * BIT_NS);
                rstN = 1'b0;
                #25;
                assertCount++;
                if (poData !== 8'h00 || poFlag !== 1'b0 || frameErr !== 1'b0 || parErr !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL midreset_outputs: got data=%h flag=%b ferr=%b perr=%b, expected 00/0/0/0",
                             poData, poFlag, frameErr, parErr);
                end
                rstN = 1'b1;
            end
        join
        assertCount++;
        if (flagQ.size() != 0 || frameErrCnt != 0) begin
            failCount++;
            $display("[TB] FAIL midreset_discard: got flags=%0d frame_errs=%0d, expected 0/0", flagQ.size(), frameErrCnt);
        end
        sendFrame(0, 8'h81, 0, 1'b0, 1'b1, BIT_NS, 2);
        assertCount++;
        if (flagQ.size() != 1 || poData !== 8'h81) begin
            failCount++;
            $display("[TB] FAIL midreset_next: got flags=%0d data=%h, expected 1/81", flagQ.size(), poData);
        end
    endtask

    task automatic test_baud_skew();
        clearEvents();
        sendFrame(0, 8'hC6, 0, 1'b0, 1'b1, BIT_NS / 1.03, 2);
        assertCount++;
        if (flagQ.size() != 1 || poData !== 8'hC6) begin
            failCount++;
            $display("[TB] FAIL skew_fast: got flags=%0d data=%h, expected 1/c6", flagQ.size(), poData);
        end
        clearEvents();
        sendFrame(0, 8'hC6, 0, 1'b0, 1'b1, BIT_NS / 0.97, 2);
        assertCount++;
        if (flagQ.size() != 1 || poData !== 8'hC6) begin
            failCount++;
            $display("[TB] FAIL skew_slow: got flags=%0d data=%h, expected 1/c6", flagQ.size(), poData);
        end
    endtask

    task automatic test_random_bytes();
        logic [7:0] expQ[$];
        logic [7:0] b;
        realtime bitNs;
        clearEvents();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            bitNs = BIT_NS * real'($urandom_range(98, 102)) / 100.0;
            sendFrame(0, b, 0, 1'b0, 1'b1, bitNs, int'($urandom_range(0, 2)));
            expQ.push_back(b);
        end
        #(2 * BIT_NS);
        assertCount++;
        if (flagQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL rand_count: got %0d, expected %0d", flagQ.size(), expQ.size()); end
        else begin
            for (int i = 0; i < expQ.size(); i++) begin
                assertCount++;
                if (flagQ[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL rand_data[%0d]: got %h, expected %h", i, flagQ[i], expQ[i]); end
            end
        end
        assertCount++;
        if (frameErrCnt != 0) begin failCount++; $display("[TB] FAIL rand_frame_err: got %0d, expected 0", frameErrCnt); end
    endtask

    task automatic test_pulse_rules();
        assertCount++;
        if (ruleViol != 0) begin failCount++; $display("[TB] FAIL pulse_rules: got %0d violations, expected 0", ruleViol); end
        assertCount++;
        if (ruleViolP != 0) begin failCount++; $display("[TB] FAIL pulse_rules_par: got %0d violations, expected 0", ruleViolP); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_parity();
        test_reset_midframe();
        test_baud_skew();
        test_random_bytes();
        test_pulse_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
